// File: rtl/sram_stream_fifo.sv
// Stream FIFO controller in front of a 64-word 1RW1R SRAM macro: port 0 writes from the
// upstream stream, port 1 reads into a two-entry output buffer feeding the downstream stream.
module sram_stream_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr1_q;
  logic [DATA_WIDTH-1:0] din0_q;
  logic [DATA_WIDTH-1:0] obuf0_q, obuf0_d, obuf1_q, obuf1_d;
  logic [CW-1:0]         words_q, words_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic                  push_s, pop_s, issue_s;
  logic [2:0]            pending_s;

  // Handshakes and macro pin drive; address/data pins hold their last value when idle
  always_comb begin
    s_ready   = !rst && (words_q < CW'(DEPTH));
    push_s    = s_valid && s_ready;
    m_valid   = (occ_q != 2'd0);
    pop_s     = m_valid && m_ready;
    pending_s = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    issue_s   = !rst && (words_q != {CW{1'b0}}) && (pending_s < 3'd2);

    sram_csb0 = !push_s;
    sram_web0 = !push_s;
    if (push_s) begin
      sram_addr0 = wptr_q;
      sram_din0  = s_data;
    end else begin
      sram_addr0 = addr0_q;
      sram_din0  = din0_q;
    end

    sram_csb1 = !issue_s;
    if (issue_s) begin
      sram_addr1 = rptr_q;
    end else begin
      sram_addr1 = addr1_q;
    end

    m_data = obuf0_q;
    count  = words_q + CW'(inflight_q) + CW'(occ_q);
  end

  // Next-state for pointers, SRAM occupancy and the output buffer
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    words_d = words_q;
    obuf0_d = obuf0_q;
    obuf1_d = obuf1_q;
    occ_d   = occ_q;

    if (push_s) begin
      wptr_d = wptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      wptr_d = wptr_q;
    end

    if (issue_s) begin
      rptr_d = rptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      rptr_d = rptr_q;
    end

    case ({push_s, issue_s})
      2'b10:   words_d = words_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   words_d = words_q - {{(CW-1){1'b0}}, 1'b1};
      default: words_d = words_q;
    endcase

    // Pop shifts the head first, so returning data lands right behind what remains
    if (pop_s) begin
      obuf0_d = obuf1_q;
      occ_d   = occ_q - 2'd1;
    end else begin
      occ_d   = occ_q;
    end

    if (inflight_q) begin
      if (occ_d == 2'd0) begin
        obuf0_d = sram_dout1;
      end else begin
        obuf1_d = sram_dout1;
      end
      occ_d = occ_d + 2'd1;
    end else begin
      occ_d = occ_d;
    end
  end

  // State registers; reset also drops any read still in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= {ADDR_WIDTH{1'b0}};
      rptr_q     <= {ADDR_WIDTH{1'b0}};
      addr0_q    <= {ADDR_WIDTH{1'b0}};
      addr1_q    <= {ADDR_WIDTH{1'b0}};
      din0_q     <= {DATA_WIDTH{1'b0}};
      obuf0_q    <= {DATA_WIDTH{1'b0}};
      obuf1_q    <= {DATA_WIDTH{1'b0}};
      words_q    <= {CW{1'b0}};
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      addr0_q    <= sram_addr0;
      addr1_q    <= sram_addr1;
      din0_q     <= sram_din0;
      obuf0_q    <= obuf0_d;
      obuf1_q    <= obuf1_d;
      words_q    <= words_d;
      occ_q      <= occ_d;
      inflight_q <= issue_s;
    end
  end

endmodule
